// File: rtl/cache_refill_if.sv
// cache_refill_if: miss, memory, critical-word and fill signals of the cache
// refill stage, bundled into one interface.
//   master : the refill engine (cache_refill)
//   slave  : its environment (cache, memory, requester)
interface cache_refill_if #(
    parameter int TAG_BITS         = 30,
    parameter int NUM_BLOCKS       = 4,
    parameter int BLOCK_SIZE_BYTES = 8
);
    localparam int IDX_BITS  = $clog2(NUM_BLOCKS);
    localparam int W         = BLOCK_SIZE_BYTES * 8;
    localparam int ADDR_BITS = TAG_BITS + IDX_BITS;
    localparam int DATA_BITS = TAG_BITS + NUM_BLOCKS * W;

    logic                 miss_valid;
    logic [ADDR_BITS-1:0] miss_addr;
    logic                 miss_ready;
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_gnt;
    logic                 mem_rvalid;
    logic [W-1:0]         mem_rdata;
    logic                 crit_valid;
    logic [W-1:0]         crit_data;
    logic                 fill_valid;
    logic [DATA_BITS-1:0] fill_line;
    logic                 fill_ready;
    logic                 busy;

    modport master (
        input  miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata, fill_ready,
        output miss_ready, mem_req, mem_addr, crit_valid, crit_data,
               fill_valid, fill_line, busy
    );

    modport slave (
        output miss_valid, miss_addr, mem_gnt, mem_rvalid, mem_rdata, fill_ready,
        input  miss_ready, mem_req, mem_addr, crit_valid, crit_data,
               fill_valid, fill_line, busy
    );
endinterface

// File: rtl/cache_refill.sv
// cache_refill: miss-handling stage in front of the cache storage.
// On a miss it reads every block of the missing line from memory (one request
// and one beat per block), forwards the requested block as soon as it arrives
// and offers the assembled {tag, blocks} line on the fill port.
// Optional build macro CACHE_REFILL_CWF_EN: fetch the requested block first and
// wrap around; when undefined, blocks are fetched in order 0..NUM_BLOCKS-1.
module cache_refill #(
    parameter int TAG_BITS         = 30,
    parameter int NUM_BLOCKS       = 4,
    parameter int BLOCK_SIZE_BYTES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    cache_refill_if.master bus
);
    localparam int IDX_BITS  = $clog2(NUM_BLOCKS);
    localparam int W         = BLOCK_SIZE_BYTES * 8;
    localparam int ADDR_BITS = TAG_BITS + IDX_BITS;
    localparam int DATA_BITS = TAG_BITS + NUM_BLOCKS * W;
    localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } state_t;

    state_t                         state_q;
    logic [TAG_BITS-1:0]            tag_q;
    logic [IDX_BITS-1:0]            req_idx_q;
    logic [IDX_BITS-1:0]            cur_idx_q;
    logic [IDX_BITS-1:0]            beat_cnt_q;
    logic [NUM_BLOCKS-1:0][W-1:0]   line_q;
    logic                           miss_ready_q;
    logic                           mem_req_q;
    logic [ADDR_BITS-1:0]           mem_addr_q;
    logic                           crit_valid_q;
    logic [W-1:0]                   crit_data_q;
    logic                           fill_valid_q;
    logic                           busy_q;

    logic [TAG_BITS-1:0]            miss_tag;
    logic [IDX_BITS-1:0]            miss_idx;
    logic [IDX_BITS-1:0]            start_idx_d;
    logic [IDX_BITS-1:0]            cur_idx_d;

    // Split the miss address and pick the first block to fetch and the next one.
    always_comb begin
        miss_tag = bus.miss_addr[ADDR_BITS-1 -: TAG_BITS];
        miss_idx = bus.miss_addr[IDX_BITS-1:0];
`ifdef CACHE_REFILL_CWF_EN
        start_idx_d = miss_idx;
`else
        start_idx_d = '0;
`endif
        // NUM_BLOCKS is a power of two, so the natural overflow is the wrap.
        cur_idx_d = cur_idx_q + IDX_BITS'(1);
    end

    // Refill FSM: every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            req_idx_q    <= '0;
            cur_idx_q    <= '0;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            miss_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            fill_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // The critical-word strobe is a single-cycle pulse.
            crit_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    miss_ready_q <= 1'b1;
                    if (bus.miss_valid && miss_ready_q) begin
                        tag_q        <= miss_tag;
                        req_idx_q    <= miss_idx;
                        cur_idx_q    <= start_idx_d;
                        beat_cnt_q   <= '0;
                        mem_req_q    <= 1'b1;
                        mem_addr_q   <= {miss_tag, start_idx_d};
                        miss_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // A beat arriving together with the grant is not taken here.
                    if (bus.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        line_q[cur_idx_q] <= bus.mem_rdata;
                        if (cur_idx_q == req_idx_q) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= bus.mem_rdata;
                        end
                        cur_idx_q  <= cur_idx_d;
                        beat_cnt_q <= beat_cnt_q + IDX_BITS'(1);
                        if (beat_cnt_q == LAST_BEAT) begin
                            fill_valid_q <= 1'b1;
                            state_q      <= FILL;
                        end else begin
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= {tag_q, cur_idx_d};
                            state_q    <= REQ;
                        end
                    end
                end
                FILL: begin
                    // Line and tag are untouched here, so fill_line holds steady.
                    if (bus.fill_ready) begin
                        fill_valid_q <= 1'b0;
                        miss_ready_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.miss_ready = miss_ready_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_data  = crit_data_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_line  = {tag_q, line_q};
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_cache_refill.sv
// tb_cache_refill: randomized self-checking bench for cache_refill with a
// behavioural memory responder and a reference model of fetch order,
// critical-word timing and line assembly.
module tb_cache_refill;
    localparam int TB  = 30;
    localparam int NB  = 4;
    localparam int BSB = 8;
    localparam int IB  = $clog2(NB);
    localparam int W   = BSB * 8;
    localparam int AB  = TB + IB;
    localparam int DB  = TB + NB * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_refill_if #(.TAG_BITS(TB), .NUM_BLOCKS(NB), .BLOCK_SIZE_BYTES(BSB)) bus ();

    cache_refill #(.TAG_BITS(TB), .NUM_BLOCKS(NB), .BLOCK_SIZE_BYTES(BSB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Memory contents of the line currently being refilled, indexed by block.
    logic [W-1:0] blk [NB];
    int gnt_delay = 0;
    int rv_delay = 0;
    int inject_req = 0;

    // Written only by the responder/monitor process.
    logic [AB-1:0] addr_log [$];
    int beats = 0, crit_n = 0, crit_at = 0, fill_rise = 0, stab_err = 0, mr_err = 0;
    int inject_done = 0;
    logic [W-1:0] crit_d = '0;
    bit pend = 0, req_prev = 0, fill_prev = 0;
    int pend_cnt = 0, age = 0;
    logic [IB-1:0] pend_idx = '0;
    logic [AB-1:0] addr_prev = '0;

    // Observations of the last run_refill.
    bit o_ok;
    int o_lat, o_unst, o_first, o_crit, o_crit_at, o_stab, o_mr, o_fill;
    logic [W-1:0] o_crit_d;
    logic [DB-1:0] o_line;
    logic o_mr_after, o_fv_after;

    // ---------------- reference model ----------------
    function automatic int exp_idx(int req, int k);
        int base = 0;
`ifdef CACHE_REFILL_CWF_EN
        base = req;
`endif
        return (base + k) % NB;
    endfunction

    function automatic int exp_crit_beat(int req);
        for (int k = 0; k < NB; k++) if (exp_idx(req, k) == req) return k + 1;
        return 0;
    endfunction

    function automatic logic [DB-1:0] exp_line(logic [TB-1:0] tag);
        logic [DB-1:0] l;
        l = '0;
        l[DB-1 -: TB] = tag;
        for (int i = 0; i < NB; i++) l[i*W +: W] = blk[i];
        return l;
    endfunction

    // ---------------- memory responder and monitor ----------------
    initial begin
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.crit_valid) begin
                crit_n++;
                crit_d = bus.crit_data;
                crit_at = beats;
            end
            if (bus.fill_valid && !fill_prev) fill_rise++;
            fill_prev = bus.fill_valid;
            if (bus.miss_ready && bus.busy) mr_err++;
            if (bus.mem_req && req_prev && bus.mem_addr !== addr_prev) stab_err++;
            req_prev = bus.mem_req;
            addr_prev = bus.mem_addr;

            bus.mem_gnt = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 0;
                age = 0;
            end else if (inject_req != inject_done) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata = {$urandom, $urandom};
                inject_done++;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata = blk[pend_idx];
                    pend = 0;
                    beats++;
                end else pend_cnt--;
            end else if (bus.mem_req) begin
                if (age >= gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    addr_log.push_back(bus.mem_addr);
                    pend = 1;
                    pend_cnt = rv_delay;
                    pend_idx = bus.mem_addr[IB-1:0];
                    age = 0;
                end else age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic run_refill(input logic [AB-1:0] a, input int gd, input int rd, input int hold);
        int b0, c0, s0, m0, f0, n;
        gnt_delay = gd;
        rv_delay = rd;
        o_first = addr_log.size();
        b0 = beats; c0 = crit_n; s0 = stab_err; m0 = mr_err; f0 = fill_rise;
        o_ok = 0; o_lat = 0; o_unst = 0; o_line = '0;
        n = 0;
        while (!bus.miss_ready && n < 50) begin @(negedge clk); n++; end
        if (bus.miss_ready) begin
            bus.miss_addr = a;
            bus.miss_valid = 1'b1;
            @(negedge clk);
            bus.miss_valid = 1'b0;
            o_lat = 1;
            while (!bus.fill_valid && o_lat < 2000) begin @(negedge clk); o_lat++; end
            if (bus.fill_valid) begin
                o_ok = 1;
                o_line = bus.fill_line;
                repeat (hold) begin
                    @(negedge clk);
                    if (!bus.fill_valid || bus.fill_line !== o_line || bus.miss_ready) o_unst++;
                end
                bus.fill_ready = 1'b1;
                @(negedge clk);
                bus.fill_ready = 1'b0;
            end
        end
        o_mr_after = bus.miss_ready;
        o_fv_after = bus.fill_valid;
        repeat (2) @(negedge clk);
        o_crit = crit_n - c0;
        o_crit_at = crit_at - b0;
        o_crit_d = crit_d;
        o_stab = stab_err - s0;
        o_mr = mr_err - m0;
        o_fill = fill_rise - f0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (bus.miss_ready !== 1'b0) $display("FAIL reset_miss_ready got %b want 0", bus.miss_ready); else n_pass++;
        n_chk++; if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b want 0", bus.mem_req); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_chk++;
        if ({bus.fill_valid, bus.crit_valid, bus.fill_line, bus.crit_data, bus.mem_addr} !== '0)
            $display("FAIL reset_outputs got fv=%b cv=%b addr=%h want all 0", bus.fill_valid, bus.crit_valid, bus.mem_addr);
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (bus.miss_ready !== 1'b1) $display("FAIL idle_miss_ready got %b want 1", bus.miss_ready); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_basic();
        logic [DB-1:0] want;
        for (int i = 0; i < NB; i++) blk[i] = W'(32'hA0 + i);
        want = {30'h4, 64'hA3, 64'hA2, 64'hA1, 64'hA0};
        run_refill(32'h0000_0012, 0, 0, 0);
        n_chk++; if (o_ok !== 1'b1) $display("FAIL basic_complete got %b want 1", o_ok); else n_pass++;
        n_chk++; if (o_lat != 2*NB+1) $display("FAIL basic_latency got %0d want %0d", o_lat, 2*NB+1); else n_pass++;
        n_chk++; if (addr_log.size() - o_first != NB) $display("FAIL basic_grants got %0d want %0d", addr_log.size() - o_first, NB); else n_pass++;
        for (int k = 0; k < NB; k++) begin
            logic [AB-1:0] ea;
            ea = {30'h4, IB'(exp_idx(2, k))};
            n_chk++; if (addr_log[o_first+k] !== ea) $display("FAIL basic_addr%0d got %h want %h", k, addr_log[o_first+k], ea); else n_pass++;
        end
        n_chk++; if (o_crit != 1) $display("FAIL basic_crit_count got %0d want 1", o_crit); else n_pass++;
        n_chk++; if (o_crit_d !== 64'hA2) $display("FAIL basic_crit_data got %h want a2", o_crit_d); else n_pass++;
        n_chk++; if (o_crit_at != exp_crit_beat(2)) $display("FAIL basic_crit_beat got %0d want %0d", o_crit_at, exp_crit_beat(2)); else n_pass++;
        n_chk++; if (o_line !== want) $display("FAIL basic_fill_line got %h want %h", o_line, want); else n_pass++;
        n_chk++; if (o_mr_after !== 1'b1) $display("FAIL basic_ready_after_fill got %b want 1", o_mr_after); else n_pass++;
        n_chk++; if (o_fv_after !== 1'b0) $display("FAIL basic_fill_drop got %b want 0", o_fv_after); else n_pass++;
        n_chk++; if (o_fill != 1) $display("FAIL basic_fill_count got %0d want 1", o_fill); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [TB-1:0] tag;
        tag = TB'($urandom);
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        run_refill({tag, 2'd1}, 5, 0, 10);
        n_chk++; if (o_ok !== 1'b1) $display("FAIL bp_complete got %b want 1", o_ok); else n_pass++;
        n_chk++; if (o_lat != 2*NB+1+5*NB) $display("FAIL bp_latency got %0d want %0d", o_lat, 2*NB+1+5*NB); else n_pass++;
        n_chk++; if (o_stab != 0) $display("FAIL bp_req_stable got %0d changes want 0", o_stab); else n_pass++;
        n_chk++; if (o_unst != 0) $display("FAIL bp_fill_stable got %0d bad cycles want 0", o_unst); else n_pass++;
        n_chk++; if (o_mr != 0) $display("FAIL bp_miss_ready_busy got %0d cycles want 0", o_mr); else n_pass++;
        n_chk++; if (o_fill != 1) $display("FAIL bp_fill_count got %0d want 1", o_fill); else n_pass++;
        n_chk++; if (o_line !== exp_line(tag)) $display("FAIL bp_fill_line got %h want %h", o_line, exp_line(tag)); else n_pass++;
        n_chk++; if (addr_log.size() - o_first != NB) $display("FAIL bp_grants got %0d want %0d", addr_log.size() - o_first, NB); else n_pass++;
    endtask

    task automatic test_busy_reject();
        int m0, first, n;
        logic [DB-1:0] l1;
        m0 = mr_err;
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        gnt_delay = 1;
        rv_delay = 0;
        first = addr_log.size();
        n = 0;
        while (!bus.miss_ready && n < 50) begin @(negedge clk); n++; end
        bus.miss_addr = 32'h0000_0012;
        bus.miss_valid = 1'b1;
        @(negedge clk);
        bus.miss_addr = 32'h0000_0020;
        n = 0;
        while (!bus.fill_valid && n < 2000) begin @(negedge clk); n++; end
        l1 = bus.fill_line;
        n_chk++; if (l1 !== exp_line(30'h4)) $display("FAIL busy_first_line got %h want %h", l1, exp_line(30'h4)); else n_pass++;
        n_chk++; if (addr_log.size() - first != NB) $display("FAIL busy_first_grants got %0d want %0d", addr_log.size() - first, NB); else n_pass++;
        bus.fill_ready = 1'b1;
        @(negedge clk);
        bus.fill_ready = 1'b0;
        n_chk++; if ({bus.busy, bus.miss_ready} !== 2'b01) $display("FAIL busy_handshake_cycle got busy=%b ready=%b want 0 1", bus.busy, bus.miss_ready); else n_pass++;
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        first = addr_log.size();
        @(negedge clk);
        bus.miss_valid = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) $display("FAIL busy_accept_in_idle got %b want 1", bus.busy); else n_pass++;
        n = 0;
        while (!bus.fill_valid && n < 2000) begin @(negedge clk); n++; end
        n_chk++; if (bus.fill_line !== exp_line(30'h8)) $display("FAIL busy_second_line got %h want %h", bus.fill_line, exp_line(30'h8)); else n_pass++;
        for (int k = 0; k < NB; k++) begin
            logic [AB-1:0] ea;
            ea = {30'h8, IB'(exp_idx(0, k))};
            n_chk++; if (addr_log[first+k] !== ea) $display("FAIL busy_second_addr%0d got %h want %h", k, addr_log[first+k], ea); else n_pass++;
        end
        bus.fill_ready = 1'b1;
        @(negedge clk);
        bus.fill_ready = 1'b0;
        n_chk++; if (mr_err - m0 != 0) $display("FAIL busy_miss_ready_while_busy got %0d cycles want 0", mr_err - m0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int b0, c0, f0, n;
        logic [TB-1:0] tag;
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        gnt_delay = 0;
        rv_delay = 1;
        b0 = beats;
        n = 0;
        while (!bus.miss_ready && n < 50) begin @(negedge clk); n++; end
        bus.miss_addr = 32'h0000_0033;
        bus.miss_valid = 1'b1;
        @(negedge clk);
        bus.miss_valid = 1'b0;
        n = 0;
        while (beats - b0 < 2 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({bus.miss_ready, bus.mem_req, bus.busy, bus.fill_valid, bus.crit_valid, bus.fill_line, bus.crit_data, bus.mem_addr} !== '0)
            $display("FAIL midreset_outputs got req=%b busy=%b fv=%b cv=%b want all 0", bus.mem_req, bus.busy, bus.fill_valid, bus.crit_valid);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        c0 = crit_n;
        f0 = fill_rise;
        inject_req++;
        repeat (6) @(negedge clk);
        n_chk++; if (crit_n - c0 != 0) $display("FAIL midreset_no_crit got %0d pulses want 0", crit_n - c0); else n_pass++;
        n_chk++; if (fill_rise - f0 != 0) $display("FAIL midreset_no_fill got %0d fills want 0", fill_rise - f0); else n_pass++;
        n_chk++; if ({bus.busy, bus.mem_req, bus.miss_ready} !== 3'b001) $display("FAIL midreset_idle got busy=%b req=%b ready=%b want 0 0 1", bus.busy, bus.mem_req, bus.miss_ready); else n_pass++;
        tag = TB'($urandom);
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        run_refill({tag, 2'd2}, 0, 0, 0);
        n_chk++; if (o_line !== exp_line(tag)) $display("FAIL midreset_refill_line got %h want %h", o_line, exp_line(tag)); else n_pass++;
        n_chk++; if (o_crit_d !== blk[2]) $display("FAIL midreset_refill_crit got %h want %h", o_crit_d, blk[2]); else n_pass++;
        n_chk++; if (o_lat != 2*NB+1) $display("FAIL midreset_refill_latency got %0d want %0d", o_lat, 2*NB+1); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
        run_refill(32'h0000_0017, 0, 0, 0);
        for (int k = 0; k < NB; k++) begin
            logic [AB-1:0] ea;
            ea = {30'h5, IB'(exp_idx(3, k))};
            n_chk++; if (addr_log[o_first+k] !== ea) $display("FAIL wrap_addr%0d got %h want %h", k, addr_log[o_first+k], ea); else n_pass++;
        end
        n_chk++; if (o_line !== exp_line(30'h5)) $display("FAIL wrap_fill_line got %h want %h", o_line, exp_line(30'h5)); else n_pass++;
        n_chk++; if (o_crit_d !== blk[3]) $display("FAIL wrap_crit_data got %h want %h", o_crit_d, blk[3]); else n_pass++;
        n_chk++; if (o_crit_at != exp_crit_beat(3)) $display("FAIL wrap_crit_beat got %0d want %0d", o_crit_at, exp_crit_beat(3)); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [TB-1:0] tag;
            int idx;
            tag = TB'($urandom);
            idx = int'($urandom_range(NB-1, 0));
            for (int i = 0; i < NB; i++) blk[i] = {$urandom, $urandom};
            run_refill({tag, IB'(idx)}, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
            n_chk++; if (o_ok !== 1'b1) $display("FAIL rnd%0d_complete got %b want 1", it, o_ok); else n_pass++;
            n_chk++; if (addr_log.size() - o_first != NB) $display("FAIL rnd%0d_grants got %0d want %0d", it, addr_log.size() - o_first, NB); else n_pass++;
            for (int k = 0; k < NB; k++) begin
                logic [AB-1:0] ea;
                ea = {tag, IB'(exp_idx(idx, k))};
                n_chk++; if (addr_log[o_first+k] !== ea) $display("FAIL rnd%0d_addr%0d got %h want %h", it, k, addr_log[o_first+k], ea); else n_pass++;
            end
            n_chk++; if (o_crit != 1) $display("FAIL rnd%0d_crit_count got %0d want 1", it, o_crit); else n_pass++;
            n_chk++; if (o_crit_d !== blk[idx]) $display("FAIL rnd%0d_crit_data got %h want %h", it, o_crit_d, blk[idx]); else n_pass++;
            n_chk++; if (o_crit_at != exp_crit_beat(idx)) $display("FAIL rnd%0d_crit_beat got %0d want %0d", it, o_crit_at, exp_crit_beat(idx)); else n_pass++;
            n_chk++; if (o_line !== exp_line(tag)) $display("FAIL rnd%0d_fill_line got %h want %h", it, o_line, exp_line(tag)); else n_pass++;
            n_chk++; if (o_stab + o_unst + o_mr != 0) $display("FAIL rnd%0d_stability got %0d/%0d/%0d want 0/0/0", it, o_stab, o_unst, o_mr); else n_pass++;
            n_chk++; if (o_fill != 1) $display("FAIL rnd%0d_fill_count got %0d want 1", it, o_fill); else n_pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached, %0d/%0d done", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.miss_valid = 1'b0;
        bus.miss_addr = '0;
        bus.fill_ready = 1'b0;
        for (int i = 0; i < NB; i++) blk[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
